dmem_resp: RTL and testbench

- Data-memory responder for the execute stage's load/store request channel.
- Accepts one request at a time: a store (SB/SH/SW, C.SW/C.SWSP) or a load (LB/LBU/LH/LHU/LW, C.LW/C.LWSP).
- Applies a configurable number of wait states, then returns a single-cycle response carrying load data or an error flag.
- Owns the word-organised data RAM and performs byte-lane merging and sign/zero extension, so the execute stage sees a clean 32-bit result.

---
 rtl/dmem_resp.sv | 269 ++++++++++++++++++++++++++
 tb/tb_dmem_resp.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// ---------------------------------------------------------------------------
// dmem_resp
//
// Data-memory responder for the execute stage's load/store request channel.
// One request is accepted at a time. After WAIT_CYCLES wait states a single
// cycle response is returned carrying either the extended load data or an
// error flag. The block owns the word-organised RAM and performs the byte
// lane merging for sub-word stores and the sign/zero extension for sub-word
// loads, so the execute stage always sees a clean 32-bit result.
//
// Parameters:
//   BASE_ADDR    byte address of RAM word 0
//   DEPTH_WORDS  number of 32-bit RAM words (power of two, >= 2)
//   WAIT_CYCLES  wait states between accept and response (0..15)
//
// Ports:
//   clk_i           clock, all state changes on the rising edge
//   rst_i           asynchronous active-high reset
//   req_valid_i     request present
//   req_we_i        1 = store, 0 = load
//   req_addr_i      byte address
//   req_wdata_i     store data, right-aligned
//   req_size_i      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i  loads: 1 = zero-extend, 0 = sign-extend
//   req_ready_o     a request can be accepted this cycle
//   rsp_valid_o     one-cycle response strobe
//   rsp_rdata_o     load result (0 for stores and errors)
//   rsp_err_o       request faulted, qualified by rsp_valid_o
// ---------------------------------------------------------------------------
module dmem_resp #(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  // Size of the mapped window in bytes, kept one bit wider than an address
  // so the range compare cannot overflow.
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_size;
  logic        lat_unsigned;

  logic [31:0] mem [DEPTH_WORDS];

  logic        op_we;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [1:0]  op_size;
  logic        op_unsigned;

  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;
  logic             op_err;

  logic             enter_resp;
  logic             mem_we;
  logic [31:0]      old_word;
  logic [3:0]       lane_en;
  logic [31:0]      lane_data;
  logic [31:0]      merged_word;
  logic [31:0]      byte_shift;
  logic [7:0]       load_byte;
  logic [15:0]      load_half;
  logic [31:0]      load_data;
  logic [31:0]      rsp_rdata_next;

  // The request being decoded. In IDLE the live inputs are used so that a
  // zero-wait build can respond on the accept edge itself; afterwards only
  // the latched copy matters, which makes later input changes harmless.
  always_comb begin
    if (state == ST_IDLE) begin
      op_we       = req_we_i;
      op_addr     = req_addr_i;
      op_wdata    = req_wdata_i;
      op_size     = req_size_i;
      op_unsigned = req_unsigned_i;
    end else begin
      op_we       = lat_we;
      op_addr     = lat_addr;
      op_wdata    = lat_wdata;
      op_size     = lat_size;
      op_unsigned = lat_unsigned;
    end
  end

  // Address decode and fault detection. The offset wraps, so addresses
  // below BASE_ADDR become huge offsets and fall out of range naturally.
  always_comb begin
    offset   = op_addr - BASE_ADDR;
    in_range = ({1'b0, offset} < SPAN_BYTES);
    word_idx = offset[IDX_W+1:2];
    op_err   = 1'b0;
    if (op_size == 2'b11) begin
      op_err = 1'b1;
    end
    if ((op_size == 2'b01) && op_addr[0]) begin
      op_err = 1'b1;
    end
    if ((op_size == 2'b10) && (op_addr[1:0] != 2'b00)) begin
      op_err = 1'b1;
    end
    if (!in_range) begin
      op_err = 1'b1;
    end
  end

  // The edge that enters RESP is where the RAM is written and the load
  // result captured. Gating with reset keeps a pending store from landing
  // while reset is held.
  always_comb begin
    enter_resp = 1'b0;
    if (!rst_i) begin
      case (state)
        ST_IDLE: enter_resp = req_valid_i && (WAIT_CYCLES == 0);
        ST_WAIT: enter_resp = (wait_cnt == 4'd1);
        default: enter_resp = 1'b0;
      endcase
    end
  end

  assign old_word = mem[word_idx];
  assign mem_we   = enter_resp && op_we && !op_err;

  // Store lane merge: replicate the right-aligned data across the word and
  // let the lane enables pick which bytes replace the stored ones.
  always_comb begin
    lane_en   = 4'b0000;
    lane_data = op_wdata;
    case (op_size)
      2'b00: begin
        lane_en   = 4'b0001 << op_addr[1:0];
        lane_data = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = op_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{op_wdata[15:0]}};
      end
      2'b10: begin
        lane_en   = 4'b1111;
        lane_data = op_wdata;
      end
      default: begin
        lane_en   = 4'b0000;
        lane_data = op_wdata;
      end
    endcase
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) begin
        merged_word[8*i +: 8] = lane_data[8*i +: 8];
      end
    end
  end

  // Load extraction and sign/zero extension.
  always_comb begin
    byte_shift = old_word >> {op_addr[1:0], 3'b000};
    load_byte  = byte_shift[7:0];
    load_half  = op_addr[1] ? old_word[31:16] : old_word[15:0];
    case (op_size)
      2'b00:   load_data = {{24{load_byte[7] & ~op_unsigned}}, load_byte};
      2'b01:   load_data = {{16{load_half[15] & ~op_unsigned}}, load_half};
      2'b10:   load_data = old_word;
      default: load_data = 32'h0;
    endcase
    rsp_rdata_next = (op_we || op_err) ? 32'h0 : load_data;
  end

  // RAM array; deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[word_idx] <= merged_word;
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      wait_cnt     <= 4'd0;
      req_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= 32'h0;
      rsp_err_o    <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr     <= 32'h0;
      lat_wdata    <= 32'h0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rsp_valid_o <= 1'b0;
          if (req_valid_i) begin
            lat_we       <= req_we_i;
            lat_addr     <= req_addr_i;
            lat_wdata    <= req_wdata_i;
            lat_size     <= req_size_i;
            lat_unsigned <= req_unsigned_i;
            req_ready_o  <= 1'b0;
            if (enter_resp) begin
              state       <= ST_RESP;
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= rsp_rdata_next;
              rsp_err_o   <= op_err;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= 4'(WAIT_CYCLES);
            end
          end
        end
        ST_WAIT: begin
          if (enter_resp) begin
            state       <= ST_RESP;
            wait_cnt    <= 4'd0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= rsp_rdata_next;
            rsp_err_o   <= op_err;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state       <= ST_IDLE;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
          rsp_rdata_o <= 32'h0;
          rsp_err_o   <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          wait_cnt    <= 4'd0;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
          rsp_rdata_o <= 32'h0;
          rsp_err_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// ---------------------------------------------------------------------------
// tb_dmem_resp
//
// Drives two responders sharing one request bus and reset: dut_a with one
// wait state and dut_b with none. Requests push their hand-computed response
// (data, error, due cycle) into a per-device queue; a monitor per device
// pops and compares whenever a response strobe appears.
// ---------------------------------------------------------------------------
module tb_dmem_resp;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        valid_a;
  logic        valid_b;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_uns;

  logic        ready_a, rsp_valid_a, rsp_err_a;
  logic [31:0] rsp_rdata_a;
  logic        ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_b;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  dmem_resp #(.BASE_ADDR(32'h2000_0000), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid_a), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_unsigned_i(req_uns), .req_ready_o(ready_a), .rsp_valid_o(rsp_valid_a),
    .rsp_rdata_o(rsp_rdata_a), .rsp_err_o(rsp_err_a)
  );

  dmem_resp #(.BASE_ADDR(32'h2000_0000), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid_b), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_unsigned_i(req_uns), .req_ready_o(ready_b), .rsp_valid_o(rsp_valid_b),
    .rsp_rdata_o(rsp_rdata_b), .rsp_err_o(rsp_err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: at a negedge, cyc equals the number of rising edges seen.
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Issue one request to dut_a (sel=0) or dut_b (sel=1) and queue its
  // expected response. With scramble set, the address and data buses are
  // corrupted right after the accept edge.
  task automatic applyStimulus(input bit sel, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size,
                               input bit uns, input logic [31:0] exp_rdata,
                               input bit exp_err, input bit scramble,
                               input bit expect_rsp);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!(sel ? ready_b : ready_a) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL ready_timeout: got ready 0 expected 1 (dut %0d)", sel);
      return;
    end
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_uns   = uns;
    if (sel) valid_b = 1'b1;
    else     valid_a = 1'b1;
    @(posedge clk);
    #1;
    if (expect_rsp) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.due   = cyc + (sel ? 0 : 1);
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    if (scramble) begin
      req_addr  = addr ^ 32'h4;
      req_wdata = ~wdata;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL drain_timeout: got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
    end
  endtask

  // Monitors: every response strobe must match the oldest queued entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid_a) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL unexpected_rsp_a: got valid 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = q_a.pop_front();
        checkOutput("rdata_a", rsp_rdata_a, e.rdata);
        checkOutput("err_a", {31'b0, rsp_err_a}, {31'b0, e.err});
        checkOutput("latency_a", 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid_b) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL unexpected_rsp_b: got valid 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = q_b.pop_front();
        checkOutput("rdata_b", rsp_rdata_b, e.rdata);
        checkOutput("err_b", {31'b0, rsp_err_b}, {31'b0, e.err});
        checkOutput("latency_b", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    exp_t e;
    rst       = 1'b1;
    valid_a   = 1'b0;
    valid_b   = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_size  = 2'b00;
    req_uns   = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_ready_a", {31'b0, ready_a}, 32'd1);
    checkOutput("rst_valid_a", {31'b0, rsp_valid_a}, 32'd0);
    checkOutput("rst_rdata_a", rsp_rdata_a, 32'h0);
    checkOutput("rst_err_a", {31'b0, rsp_err_a}, 32'd0);
    checkOutput("rst_ready_b", {31'b0, ready_b}, 32'd1);
    checkOutput("rst_valid_b", {31'b0, rsp_valid_b}, 32'd0);
    rst = 1'b0;

    $display("[TB] word store/load with ready hold-off");
    applyStimulus(0, 1, 32'h2000_0010, 32'hDEAD_BEEF, 2'b10, 0, 32'h0, 0, 0, 1);
    @(negedge clk);
    checkOutput("ready_wait", {31'b0, ready_a}, 32'd0);
    @(negedge clk);
    checkOutput("ready_resp", {31'b0, ready_a}, 32'd0);
    @(negedge clk);
    checkOutput("ready_idle", {31'b0, ready_a}, 32'd1);
    applyStimulus(0, 0, 32'h2000_0010, 32'h0, 2'b10, 0, 32'hDEAD_BEEF, 0, 0, 1);

    $display("[TB] byte and half lanes");
    applyStimulus(0, 1, 32'h2000_0011, 32'h0000_0055, 2'b00, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 1, 32'h2000_0012, 32'h0000_8001, 2'b01, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 0, 32'h2000_0010, 32'h0, 2'b10, 0, 32'h8001_55EF, 0, 0, 1);
    applyStimulus(0, 0, 32'h2000_0013, 32'h0, 2'b00, 0, 32'hFFFF_FF80, 0, 0, 1);
    applyStimulus(0, 0, 32'h2000_0013, 32'h0, 2'b00, 1, 32'h0000_0080, 0, 0, 1);
    applyStimulus(0, 0, 32'h2000_0012, 32'h0, 2'b01, 0, 32'hFFFF_8001, 0, 0, 1);
    applyStimulus(0, 0, 32'h2000_0012, 32'h0, 2'b01, 1, 32'h0000_8001, 0, 0, 1);
    applyStimulus(0, 0, 32'h2000_0010, 32'h0, 2'b00, 0, 32'hFFFF_FFEF, 0, 0, 1);
    applyStimulus(0, 0, 32'h2000_0011, 32'h0, 2'b00, 1, 32'h0000_0055, 0, 0, 1);
    applyStimulus(0, 0, 32'h2000_0010, 32'h0, 2'b01, 0, 32'h0000_55EF, 0, 0, 1);

    $display("[TB] error cases and range boundary");
    applyStimulus(0, 0, 32'h2000_0012, 32'h0, 2'b10, 0, 32'h0, 1, 0, 1);
    applyStimulus(0, 1, 32'h2000_0011, 32'h0000_AAAA, 2'b01, 0, 32'h0, 1, 0, 1);
    applyStimulus(0, 0, 32'h2000_0010, 32'h0, 2'b10, 0, 32'h8001_55EF, 0, 0, 1);
    applyStimulus(0, 0, 32'h2000_1000, 32'h0, 2'b10, 0, 32'h0, 1, 0, 1);
    applyStimulus(0, 0, 32'h1FFF_FFFC, 32'h0, 2'b10, 0, 32'h0, 1, 0, 1);
    applyStimulus(0, 0, 32'h2000_0010, 32'h0, 2'b11, 0, 32'h0, 1, 0, 1);
    applyStimulus(0, 1, 32'h2000_0010, 32'h1111_1111, 2'b11, 0, 32'h0, 1, 0, 1);
    applyStimulus(0, 0, 32'h2000_0010, 32'h0, 2'b10, 0, 32'h8001_55EF, 0, 0, 1);
    applyStimulus(0, 1, 32'h2000_0FFC, 32'hCAFE_F00D, 2'b10, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 0, 32'h2000_0FFC, 32'h0, 2'b10, 0, 32'hCAFE_F00D, 0, 0, 1);

    $display("[TB] input hold-off during wait");
    applyStimulus(0, 1, 32'h2000_0034, 32'h0, 2'b10, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 1, 32'h2000_0030, 32'h1122_3344, 2'b10, 0, 32'h0, 0, 1, 1);
    applyStimulus(0, 0, 32'h2000_0034, 32'h0, 2'b10, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 0, 32'h2000_0030, 32'h0, 2'b10, 0, 32'h1122_3344, 0, 1, 1);

    $display("[TB] reset during wait");
    applyStimulus(0, 1, 32'h2000_0020, 32'h0, 2'b10, 0, 32'h0, 0, 0, 1);
    waitDrain();
    applyStimulus(0, 1, 32'h2000_0020, 32'h1234_5678, 2'b10, 0, 32'h0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_ready", {31'b0, ready_a}, 32'd1);
    checkOutput("abort_valid", {31'b0, rsp_valid_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 32'h2000_0020, 32'h0, 2'b10, 0, 32'h0, 0, 0, 1);
    waitDrain();

    $display("[TB] zero wait-state build");
    applyStimulus(1, 1, 32'h2000_0040, 32'hA5A5_0F0F, 2'b10, 0, 32'h0, 0, 0, 1);
    applyStimulus(1, 0, 32'h2000_0040, 32'h0, 2'b10, 0, 32'hA5A5_0F0F, 0, 0, 1);
    applyStimulus(1, 0, 32'h2000_0041, 32'h0, 2'b00, 0, 32'h0000_000F, 0, 0, 1);
    waitDrain();
    @(negedge clk);
    s         = cyc;
    req_we    = 1'b0;
    req_addr  = 32'h2000_0040;
    req_wdata = 32'h0;
    req_size  = 2'b01;
    req_uns   = 1'b0;
    valid_b   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e.rdata = 32'h0000_0F0F;
      e.err   = 1'b0;
      e.due   = s + 1 + 2 * k;
      q_b.push_back(e);
    end
    for (int k = 0; k < 8; k++) begin
      checkOutput("hold_ready", {31'b0, ready_b}, (k % 2 == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    valid_b = 1'b0;
    waitDrain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
